// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 UART transmitter: pops a byte, then shifts it out LSB first on txd.
// Optional even-parity bit is enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif
    localparam logic [2:0] STOP   = 3'd5;

    localparam int                   BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    logic [2:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  baud_end_s;
    logic                  pop_s;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign baud_end_s = (cnt_q == CNT_LAST);
    // A pop is only legal from IDLE or on the final STOP cycle, never during reset.
    assign pop_s = ~rst & tx_en & ~fifo_empty &
                   ((state_q == IDLE) | ((state_q == STOP) & baud_end_s));

    assign fifo_r_en = pop_s;
    assign txd       = txd_q;
    assign busy      = busy_q;
    assign tx_done   = done_q;

    // Frame sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pop_s) state_d = LOAD;
                else       state_d = IDLE;
            end
            LOAD: state_d = START;
            START: begin
                if (baud_end_s) state_d = DATA;
                else            state_d = START;
            end
            DATA: begin
                if (baud_end_s && (bit_q == BIT_LAST)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end_s) state_d = STOP;
                else            state_d = PARITY;
            end
`endif
            STOP: begin
                if (baud_end_s) state_d = pop_s ? LOAD : IDLE;
                else            state_d = STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Baud/bit counters, shift register and next values of the registered outputs.
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if ((state_d != state_q) || (state_q == IDLE) || baud_end_s) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (state_q == LOAD) begin
            bit_d   = {BIT_W{1'b0}};
            shift_d = fifo_r_data;
        end else if ((state_q == DATA) && baud_end_s && (bit_q != BIT_LAST)) begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
        end else begin
            bit_d   = bit_q;
            shift_d = shift_q;
        end
`ifdef FIFO_UART_TX_PARITY_EN
        if (state_q == LOAD) parity_d = even_parity(fifo_r_data);
        else                 parity_d = parity_q;
`endif
        // txd is registered, so it is derived from the state being entered.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_WIDTH{1'b0}};
            bit_q    <= {BIT_W{1'b0}};
            shift_q  <= {DATA_WIDTH{1'b0}};
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: FIFO model feeds bytes, a scoreboard holds the expected
// bytes and a line monitor checks every txd cycle of each frame against them.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int FRAME = (DW + 2 + PB) * CPB;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty;
    logic       fifo_r_en;
    logic [7:0] fifo_r_data;
    logic       txd;
    logic       busy;
    logic       tx_done;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_r_en(fifo_r_en), .fifo_r_data(fifo_r_data),
        .txd(txd), .busy(busy), .tx_done(tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] fq[$];
    logic [7:0] sb[$];
    int         starts[$];
    int         cyc_n = 0;
    int         pops = 0;
    int         pop_cyc = -100;
    int         dones = 0;
    int         frames_done = 0;
    logic       ren_s = 1'b0;
    logic       prev_txd = 1'b1;
    logic       dec_act = 1'b0;
    int         dec_start = 0;
    logic [7:0] dec_byte = 8'h00;
    logic [7:0] exp_byte = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic fbit(input int off, input logic [7:0] b);
        if (off < CPB)                 return 1'b0;
        else if (off < CPB * (DW + 1)) return b[off / CPB - 1];
        else if (off < CPB * (DW + 1 + PB)) return ^b;
        else                           return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        sb.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic monitor();
        int off;
        if (!dec_act && prev_txd === 1'b1 && txd === 1'b0) begin
            dec_act   = 1'b1;
            dec_start = cyc_n;
            dec_byte  = 8'h00;
            starts.push_back(cyc_n);
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            exp_byte = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        end
        if (dec_act) begin
            off = cyc_n - dec_start;
            chk($sformatf("txd_off%0d", off), {31'd0, txd}, {31'd0, fbit(off, exp_byte)});
            chk("busy_in_frame", {31'd0, busy}, 32'd1);
            chk("tx_done_frame", {31'd0, tx_done}, 32'(off == FRAME - 1));
            if (off >= CPB && off < CPB * (DW + 1) && (off % CPB) == 1) dec_byte[off / CPB - 1] = txd;
            if (off == FRAME - 1) begin
                chk("byte", {24'd0, dec_byte}, {24'd0, exp_byte});
                dec_act = 1'b0;
                frames_done++;
            end
        end else begin
            chk("tx_done_idle", {31'd0, tx_done}, 32'd0);
        end
        prev_txd = txd;
    endtask

    task automatic cyc();
        logic ren;
        #2;
        ren   = fifo_r_en;
        ren_s = ren;
        if (ren === 1'b1) begin
            pops++;
            pop_cyc = cyc_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (ren === 1'b1) fifo_r_data = (fq.size() > 0) ? fq.pop_front() : 8'h00;
        fifo_empty = (fq.size() == 0);
        if (tx_done === 1'b1) dones++;
        monitor();
        @(negedge clk);
    endtask

    task automatic run_until(input int tgt, input int budget);
        int n = 0;
        while (frames_done < tgt && n < budget) begin
            cyc();
            n++;
        end
        chk("frame_timeout", 32'(frames_done), 32'(tgt));
    endtask

    task automatic wait_off(input int o, input int budget);
        int n = 0;
        while (!(dec_act && (cyc_n - dec_start) == o) && n < budget) begin
            cyc();
            n++;
        end
        chk("wait_off_timeout", 32'(dec_act && (cyc_n - dec_start) == o), 32'd1);
    endtask

    initial begin
        int tgt;
        int lows;
        logic [7:0] b0;
        logic [7:0] b1;
        rst = 1'b1;
        tx_en = 1'b1;
        fifo_empty = 1'b1;
        fifo_r_data = 8'h00;
        @(negedge clk);

        // Reset held for 3 cycles with a byte waiting and transmission enabled.
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_txd", {31'd0, txd}, 32'd1);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_ren", {31'd0, ren_s}, 32'd0);
        end
        chk("rst_no_pop", 32'(pops), 32'd0);

        // Single byte 0xA5 after reset release.
        rst = 1'b0;
        pops = 0;
        dones = 0;
        starts.delete();
        run_until(1, 80);
        chk("single_pops", 32'(pops), 32'd1);
        chk("single_start_lat", 32'((starts.size() > 0) ? starts[0] - pop_cyc : -1), 32'd2);
        chk("single_dones", 32'(dones), 32'd1);
        cyc();
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("idle_txd", {31'd0, txd}, 32'd1);

        // Back-to-back pair.
`ifdef FIFO_UART_TX_PARITY_EN
        b0 = 8'h07;
        b1 = 8'h03;
`else
        b0 = 8'h55;
        b1 = 8'h0F;
`endif
        repeat (3) cyc();
        pops = 0;
        dones = 0;
        starts.delete();
        tgt = frames_done + 2;
        push(b0);
        push(b1);
        run_until(tgt, 150);
        chk("b2b_pops", 32'(pops), 32'd2);
        chk("b2b_dones", 32'(dones), 32'd2);
        chk("b2b_nstarts", 32'(starts.size()), 32'd2);
        chk("b2b_spacing", 32'((starts.size() >= 2) ? starts[1] - starts[0] : -1), 32'(FRAME + 1));

        // tx_en low with data waiting.
        tx_en = 1'b0;
        pops = 0;
        lows = 0;
        push(8'h33);
        repeat (50) begin
            cyc();
            if (txd !== 1'b1) lows++;
        end
        chk("gate_pops", 32'(pops), 32'd0);
        chk("gate_txd_low", 32'(lows), 32'd0);

        // tx_en dropped during data bit 2: frame completes, no further pop.
        push(8'h96);
        tgt = frames_done + 1;
        tx_en = 1'b1;
        wait_off(3 * CPB, 40);
        tx_en = 1'b0;
        run_until(tgt, 60);
        repeat (10) cyc();
        chk("drop_pops", 32'(pops), 32'd1);
        chk("drop_fifo_left", 32'(fq.size()), 32'd1);
        fq.delete();
        sb.delete();
        fifo_empty = 1'b1;
        tx_en = 1'b1;

        // Reset during data bit 3 of 0xFF.
        repeat (2) cyc();
        pops = 0;
        push(8'hFF);
        wait_off(4 * CPB, 40);
        rst = 1'b1;
        dec_act = 1'b0;
        cyc();
        chk("midrst_ren", {31'd0, ren_s}, 32'd0);
        chk("midrst_txd", {31'd0, txd}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        sb.delete();
        pops = 0;
        lows = 0;
        repeat (10) begin
            cyc();
            if (txd !== 1'b1) lows++;
        end
        chk("postrst_pops", 32'(pops), 32'd0);
        chk("postrst_txd_low", 32'(lows), 32'd0);
        tgt = frames_done + 1;
        push(8'h5A);
        run_until(tgt, 80);
        chk("postrst_new_pop", 32'(pops), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
